sbox_cfg_ctrl: RTL and testbench
================================

SBOX_CFG_CTRL -- requirements
Module: sbox_cfg_ctrl

Interface
REQ-001 Parameter SEL_W, default 3, width of S-box select (8 S-boxes).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 core_busy  in  1  DES datapath using S-boxes; edits held off while high.
REQ-005 s_wr_valid / s_wr_ready  in / out  1 / 1  single-entry write handshake.
REQ-006 s_wr_sbox, s_wr_row, s_wr_col, s_wr_val  in  SEL_W/2/4/4  single-entry target and value.
REQ-007 b_start, b_sbox  in  1 / SEL_W  bulk-load start pulse and target S-box.
REQ-008 b_valid / b_ready, b_val  in / out, in  1 / 1, 4  bulk value stream handshake.
REQ-009 b_done  out  1  one-cycle pulse after the 64th bulk beat is written.
REQ-010 edit_sbox, new_sbox_val, sbox_sel, row_sel, col_sel  out  1/4/SEL_W/2/4  registered S-box edit port.
REQ-011 cfg_busy  out  1  high whenever state is not IDLE.
REQ-012 cfg_lock, cfg_err  in / out  1 / 1  present only when SBOX_CFG_LOCK_EN is defined.

Function
REQ-013 FSM states IDLE and BULK only.
REQ-014 s_wr_ready SHALL be high iff state==IDLE, !core_busy, and no b_start this cycle.
REQ-015 Single-write handshake SHALL drive edit_sbox=1 with captured sbox/row/col/val on the next cycle, for exactly one cycle.
REQ-016 b_start in IDLE SHALL load b_sbox, clear 6-bit beat counter, enter BULK next cycle; b_start outside IDLE ignored.
REQ-017 b_start and s_wr_valid in the same IDLE cycle: bulk wins, single write stalls (not dropped).
REQ-018 b_ready SHALL be high iff state==BULK and !core_busy.
REQ-019 Each bulk handshake SHALL emit one edit next cycle with row_sel=cnt[5:4], col_sel=cnt[3:0], sbox_sel=latched b_sbox, then increment cnt.
REQ-020 Handshake at cnt==63 SHALL return to IDLE and pulse b_done in the same cycle as that final edit_sbox.
REQ-021 core_busy rising mid-bulk SHALL pause the stream (b_ready low) without losing cnt; resume on fall.
REQ-022 edit_sbox SHALL never be high in a cycle following one where core_busy was high at handshake time (handshakes are gated by core_busy).
REQ-023 At most one edit per cycle; back-to-back beats yield back-to-back edit pulses.
REQ-024 Edit-port fields SHALL hold last value when edit_sbox is low.

Reset
REQ-025 Reset SHALL force IDLE, cnt=0, edit_sbox=0, b_done=0, cfg_err=0, all edit fields 0, ready outputs 0.
REQ-026 Reset mid-bulk SHALL abort the load with no b_done; partially written entries remain as the S-box's own reset defines.

Configuration
REQ-027 Macro SBOX_CFG_LOCK_EN: when defined, cfg_lock high makes accepted single/bulk beats produce no edit and a one-cycle cfg_err pulse per dropped beat; bulk still counts and completes with b_done.
REQ-028 When SBOX_CFG_LOCK_EN is undefined, cfg_lock/cfg_err ports are absent and all accepted beats are written.

Structure
REQ-029 Shared package des_pkg SHALL hold the FSM state typedef, S-box count (8), rows (4), columns (16) and entries-per-box (64) constants.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 Single write sbox=6,row=2,col=5,val=9 with core_busy=0 -> next cycle edit_sbox=1, sbox_sel=6,row_sel=2,col_sel=5,new_sbox_val=9, one cycle.
REQ-032 b_start sbox=3, 64 beats b_val=cnt[3:0] back-to-back -> 64 consecutive edits, last row_sel=3,col_sel=15, b_done with 64th edit, cfg_busy low after.
REQ-033 core_busy=1 for 10 cycles at beat 20 -> b_ready low, no edits, resume at beat 20, total still 64 edits.
REQ-034 b_start and s_wr_valid same cycle -> bulk runs; single write accepted first IDLE cycle after b_done.
REQ-035 rst_n low at beat 30 -> outputs zero immediately, no b_done, IDLE after release.
REQ-036 SBOX_CFG_LOCK_EN, cfg_lock=1, single write -> s_wr_ready handshake, no edit_sbox, cfg_err one cycle.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg
//   Shared DES S-box configuration constants and the state type of the
//   S-box configuration controller.
//   Contents:
//     SBOX_NUM      number of S-boxes (8)
//     SBOX_ROWS     rows per S-box (4)
//     SBOX_COLS     columns per S-box (16)
//     SBOX_ENTRIES  entries per S-box (64)
//     ROW_W/COL_W/CNT_W/VAL_W  derived field widths
//     cfg_state_e   controller FSM state (IDLE, BULK)
package des_pkg;

  localparam int unsigned SBOX_NUM     = 8;
  localparam int unsigned SBOX_ROWS    = 4;
  localparam int unsigned SBOX_COLS    = 16;
  localparam int unsigned SBOX_ENTRIES = 64;

  localparam int unsigned ROW_W = $clog2(SBOX_ROWS);
  localparam int unsigned COL_W = $clog2(SBOX_COLS);
  localparam int unsigned CNT_W = $clog2(SBOX_ENTRIES);
  localparam int unsigned VAL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BULK = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/sbox_cfg_ctrl.sv
// sbox_cfg_ctrl
//   Run-time editor for the DES S-box tables. Accepts either single-entry
//   writes or a 64-beat bulk load of one S-box and turns every accepted beat
//   into a one-cycle registered edit strobe on the S-box edit port. Edits are
//   held off while the DES core is using the S-boxes (core_busy).
//
//   Optional feature (macro SBOX_CFG_LOCK_EN): adds cfg_lock/cfg_err. While
//   cfg_lock is high accepted beats are dropped (no edit) and each dropped
//   beat raises a one-cycle cfg_err; bulk loads still count and finish.
//
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     core_busy               DES datapath busy; blocks all handshakes
//     s_wr_valid/s_wr_ready   single-entry write handshake
//     s_wr_sbox/row/col/val   single-entry target and value
//     b_start, b_sbox         bulk-load start pulse and target S-box
//     b_valid/b_ready, b_val  bulk value stream
//     b_done                  pulse together with the 64th bulk edit
//     edit_sbox               one-cycle edit strobe
//     new_sbox_val, sbox_sel, row_sel, col_sel   edit fields (hold when idle)
//     cfg_busy                high while a bulk load is in progress
//     cfg_lock, cfg_err       lock input / dropped-beat pulse (macro only)
module sbox_cfg_ctrl
  import des_pkg::*;
#(
  parameter int unsigned SEL_W = $clog2(SBOX_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_busy,
  input  logic             s_wr_valid,
  output logic             s_wr_ready,
  input  logic [SEL_W-1:0] s_wr_sbox,
  input  logic [ROW_W-1:0] s_wr_row,
  input  logic [COL_W-1:0] s_wr_col,
  input  logic [VAL_W-1:0] s_wr_val,
  input  logic             b_start,
  input  logic [SEL_W-1:0] b_sbox,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [VAL_W-1:0] b_val,
  output logic             b_done,
  output logic             edit_sbox,
  output logic [VAL_W-1:0] new_sbox_val,
  output logic [SEL_W-1:0] sbox_sel,
  output logic [ROW_W-1:0] row_sel,
  output logic [COL_W-1:0] col_sel,
`ifdef SBOX_CFG_LOCK_EN
  input  logic             cfg_lock,
  output logic             cfg_err,
`endif
  output logic             cfg_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_ENTRIES - 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] bsel_q, bsel_d;

  logic             edit_q;
  logic             done_q;
  logic [VAL_W-1:0] val_q;
  logic [SEL_W-1:0] sel_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic s_hs;
  logic b_hs;
  logic bulk_last;
  logic lock;
  logic wr_en;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (b_start)   state_d = ST_BULK;
      ST_BULK: if (bulk_last) state_d = ST_IDLE;
    endcase
  end

  // s_wr_ready also gated by rst_n so both readies read 0 while in reset.
  always_comb begin
    s_wr_ready = 1'b0;
    b_ready    = 1'b0;
    cfg_busy   = 1'b0;
    unique case (state_q)
      ST_IDLE: s_wr_ready = rst_n && !core_busy && !b_start;
      ST_BULK: begin
        b_ready  = !core_busy;
        cfg_busy = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------- handshakes
  assign s_hs      = s_wr_valid && s_wr_ready;
  assign b_hs      = b_valid && b_ready;
  assign bulk_last = b_hs && (cnt_q == CNT_LAST);

`ifdef SBOX_CFG_LOCK_EN
  assign lock = cfg_lock;
`else
  assign lock = 1'b0;
`endif

  assign wr_en = (s_hs || b_hs) && !lock;

  // ------------------------------------------------ bulk beat bookkeeping
  always_comb begin
    cnt_d  = cnt_q;
    bsel_d = bsel_q;
    if (state_q == ST_IDLE && b_start) begin
      cnt_d  = '0;
      bsel_d = b_sbox;
    end else if (b_hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bsel_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bsel_q <= bsel_d;
    end
  end

  // ----------------------------------------------------------- edit port
  // s_hs and b_hs are mutually exclusive (IDLE vs BULK), so b_hs selects
  // the source. Fields only move on a real write and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_q <= 1'b0;
      done_q <= 1'b0;
      val_q  <= '0;
      sel_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      edit_q <= wr_en;
      done_q <= bulk_last;
      if (wr_en) begin
        if (b_hs) begin
          sel_q <= bsel_q;
          row_q <= cnt_q[CNT_W-1 -: ROW_W];
          col_q <= cnt_q[COL_W-1:0];
          val_q <= b_val;
        end else begin
          sel_q <= s_wr_sbox;
          row_q <= s_wr_row;
          col_q <= s_wr_col;
          val_q <= s_wr_val;
        end
      end
    end
  end

`ifdef SBOX_CFG_LOCK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (s_hs || b_hs) && cfg_lock;
    end
  end

  assign cfg_err = err_q;
`endif

  assign edit_sbox    = edit_q;
  assign b_done       = done_q;
  assign new_sbox_val = val_q;
  assign sbox_sel     = sel_q;
  assign row_sel      = row_q;
  assign col_sel      = col_q;

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// tb_sbox_cfg_ctrl
//   Self-checking bench for sbox_cfg_ctrl. Expected edits go into a queue
//   when a beat is driven that must be accepted; a negedge monitor pops and
//   compares every edit strobe and checks that fields hold between edits.
module tb_sbox_cfg_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] val;
  } edit_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       core_busy = 1'b0;
  logic       s_wr_valid = 1'b0;
  logic       s_wr_ready;
  logic [2:0] s_wr_sbox = '0;
  logic [1:0] s_wr_row = '0;
  logic [3:0] s_wr_col = '0;
  logic [3:0] s_wr_val = '0;
  logic       b_start = 1'b0;
  logic [2:0] b_sbox = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [3:0] b_val = '0;
  logic       b_done;
  logic       edit_sbox;
  logic [3:0] new_sbox_val;
  logic [2:0] sbox_sel;
  logic [1:0] row_sel;
  logic [3:0] col_sel;
  logic       cfg_busy;
  logic       cfg_lock = 1'b0;
  logic       cfg_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_edits  = 0;
  edit_t exp_q[$];
  edit_t last_exp = '0;
  logic  busy_prev = 1'b0;

  sbox_cfg_ctrl #(.SEL_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_busy    (core_busy),
    .s_wr_valid   (s_wr_valid),
    .s_wr_ready   (s_wr_ready),
    .s_wr_sbox    (s_wr_sbox),
    .s_wr_row     (s_wr_row),
    .s_wr_col     (s_wr_col),
    .s_wr_val     (s_wr_val),
    .b_start      (b_start),
    .b_sbox       (b_sbox),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_val        (b_val),
    .b_done       (b_done),
    .edit_sbox    (edit_sbox),
    .new_sbox_val (new_sbox_val),
    .sbox_sel     (sbox_sel),
    .row_sel      (row_sel),
    .col_sel      (col_sel),
`ifdef SBOX_CFG_LOCK_EN
    .cfg_lock     (cfg_lock),
    .cfg_err      (cfg_err),
`endif
    .cfg_busy     (cfg_busy)
  );

`ifndef SBOX_CFG_LOCK_EN
  assign cfg_err = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Edit monitor: every strobe must match the next queued expectation and
  // must not follow an edge at which core_busy was high.
  always @(negedge clk) begin
    edit_t obs;
    edit_t e;
    obs = '{sel: sbox_sel, row: row_sel, col: col_sel, val: new_sbox_val};
    if (!rst_n) begin
      last_exp = '0;
    end else if (edit_sbox === 1'b1) begin
      n_edits++;
      n_checks++;
      if (busy_prev !== 1'b0) begin
        n_fail++;
        $display("FAIL edit_after_busy: edit_sbox=1 with core_busy=%b at handshake edge, required 0", busy_prev);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL edit_unexpected: got edit %h, required no edit", obs);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL edit_fields: got sel=%0d row=%0d col=%0d val=%0h, required sel=%0d row=%0d col=%0d val=%0h",
                   obs.sel, obs.row, obs.col, obs.val, e.sel, e.row, e.col, e.val);
        end
      end
    end else begin
      n_checks++;
      if (obs !== last_exp) begin
        n_fail++;
        $display("FAIL edit_hold: got %h while idle, required %h", obs, last_exp);
      end
    end
    busy_prev = core_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({edit_sbox, b_done, s_wr_ready, b_ready, cfg_busy, cfg_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got edit,done,srdy,brdy,busy,err=%b, required 000000",
               {edit_sbox, b_done, s_wr_ready, b_ready, cfg_busy, cfg_err});
    end
    n_checks++;
    if ({sbox_sel, row_sel, col_sel, new_sbox_val} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h, required 0", {sbox_sel, row_sel, col_sel, new_sbox_val});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_wr_ready !== 1'b1 || b_ready !== 1'b0 || cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got srdy=%b brdy=%b busy=%b, required 1 0 0", s_wr_ready, b_ready, cfg_busy);
    end
  endtask

  task automatic test_single();
    tick();
    s_wr_valid = 1'b1; s_wr_sbox = 3'd6; s_wr_row = 2'd2; s_wr_col = 4'd5; s_wr_val = 4'd9;
    @(negedge clk);
    n_checks++;
    if (s_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b, required 1", s_wr_ready);
    end
    exp_q.push_back('{sel: 3'd6, row: 2'd2, col: 4'd5, val: 4'd9});
    tick();
    s_wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (edit_sbox !== 1'b1) begin
      n_fail++;
      $display("FAIL single_edit: got edit_sbox=%b, required 1", edit_sbox);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (edit_sbox !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: got edit_sbox=%b, required 0", edit_sbox);
    end
  endtask

  task automatic test_single_busy();
    tick();
    core_busy = 1'b1;
    s_wr_valid = 1'b1; s_wr_sbox = 3'd2; s_wr_row = 2'd1; s_wr_col = 4'd14; s_wr_val = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready: cycle %0d got %b, required 0", i, s_wr_ready);
      end
      tick();
    end
    core_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_release_ready: got %b, required 1", s_wr_ready);
    end
    exp_q.push_back('{sel: 3'd2, row: 2'd1, col: 4'd14, val: 4'd3});
    tick();
    s_wr_valid = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    edit_t d;
    for (int i = 0; i < 5; i++) begin
      tick();
      d = edit_t'($urandom);
      s_wr_valid = 1'b1;
      s_wr_sbox = d.sel; s_wr_row = d.row; s_wr_col = d.col; s_wr_val = d.val;
      @(negedge clk);
      n_checks++;
      if (s_wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: beat %0d got %b, required 1", i, s_wr_ready);
      end
      exp_q.push_back(d);
      if (i > 0) begin
        n_checks++;
        if (edit_sbox !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_edit: beat %0d got edit_sbox=%b, required 1", i, edit_sbox);
        end
      end
    end
    tick();
    s_wr_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (edit_sbox !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got edit_sbox=%b, required 0", edit_sbox);
    end
  endtask

  // Bulk load of S-box sb with b_val = beat[3:0]. Optional core_busy stall,
  // stray b_start inside BULK, competing single write, or reset at a beat.
  task automatic run_bulk(input logic [2:0] sb, input int busy_at, input int busy_len,
                          input int rst_at, input int poke_at, input bit also_single);
    int cnt = 0;
    int cyc = 0;
    int busy_left = 0;
    bit busy_used = 1'b0;
    int base = n_edits;
    tick();
    b_start = 1'b1; b_sbox = sb; b_valid = 1'b0;
    if (also_single) begin
      s_wr_valid = 1'b1; s_wr_sbox = 3'd5; s_wr_row = 2'd1; s_wr_col = 4'd7; s_wr_val = 4'hC;
    end
    @(negedge clk);
    n_checks++;
    if (s_wr_ready !== 1'b0 || cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bulk_start: got srdy=%b busy=%b, required 0 0", s_wr_ready, cfg_busy);
    end
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    while (cnt < 64 && cyc < 400) begin
      if (rst_at >= 0 && cnt == rst_at) break;
      if (busy_len > 0 && cnt == busy_at && !busy_used) begin
        busy_left = busy_len;
        busy_used = 1'b1;
      end
      core_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      b_start = (cnt == poke_at);
      b_sbox = (cnt == poke_at) ? ~sb : sb;
      b_val = 4'(cnt);
      @(negedge clk);
      n_checks++;
      if (b_ready !== !core_busy || cfg_busy !== 1'b1 || b_done !== 1'b0 || s_wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bulk_beat%0d: got brdy=%b busy=%b done=%b srdy=%b, required %b 1 0 0",
                 cnt, b_ready, cfg_busy, b_done, s_wr_ready, !core_busy);
      end
      if (!core_busy) begin
        exp_q.push_back('{sel: sb, row: 2'(cnt >> 4), col: 4'(cnt), val: 4'(cnt)});
        cnt++;
      end
      tick();
      cyc++;
    end
    b_start = 1'b0;
    b_valid = 1'b0;
    core_busy = 1'b0;
    if (cyc >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL bulk_timeout: got %0d beats, required 64", cnt);
    end else if (rst_at >= 0) begin
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      n_checks++;
      if ({edit_sbox, b_done, cfg_busy, b_ready, s_wr_ready} !== 5'b0
          || {sbox_sel, row_sel, col_sel, new_sbox_val} !== 13'd0) begin
        n_fail++;
        $display("FAIL bulk_reset_now: got edit,done,busy,brdy,srdy=%b fields=%h, required 00000 0",
                 {edit_sbox, b_done, cfg_busy, b_ready, s_wr_ready}, {sbox_sel, row_sel, col_sel, new_sbox_val});
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (b_done !== 1'b0 || cfg_busy !== 1'b0 || s_wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bulk_reset_after%0d: got done=%b busy=%b srdy=%b, required 0 0 1",
                   i, b_done, cfg_busy, s_wr_ready);
        end
      end
      n_checks++;
      if (n_edits - base !== rst_at - 1) begin
        n_fail++;
        $display("FAIL bulk_reset_edits: got %0d edits, required %0d", n_edits - base, rst_at - 1);
      end
    end else begin
      @(negedge clk);
      n_checks++;
      if (b_done !== 1'b1 || edit_sbox !== 1'b1 || cfg_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bulk_done: got done=%b edit=%b busy=%b, required 1 1 0", b_done, edit_sbox, cfg_busy);
      end
      if (also_single) begin
        n_checks++;
        if (s_wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bulk_single_after: got srdy=%b, required 1", s_wr_ready);
        end
        exp_q.push_back('{sel: 3'd5, row: 2'd1, col: 4'd7, val: 4'hC});
      end
      tick();
      s_wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b_done !== 1'b0 || edit_sbox !== also_single) begin
        n_fail++;
        $display("FAIL bulk_done_pulse: got done=%b edit=%b, required 0 %b", b_done, edit_sbox, also_single);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (n_edits - base !== 64 + int'(also_single)) begin
        n_fail++;
        $display("FAIL bulk_edits: got %0d edits, required %0d", n_edits - base, 64 + int'(also_single));
      end
    end
  endtask

`ifdef SBOX_CFG_LOCK_EN
  task automatic test_lock();
    tick();
    cfg_lock = 1'b1;
    s_wr_valid = 1'b1; s_wr_sbox = 3'd4; s_wr_row = 2'd3; s_wr_col = 4'd1; s_wr_val = 4'd8;
    @(negedge clk);
    n_checks++;
    if (s_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_ready: got %b, required 1", s_wr_ready);
    end
    tick();
    s_wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (edit_sbox !== 1'b0 || cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_drop: got edit=%b err=%b, required 0 1", edit_sbox, cfg_err);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_err_pulse: got err=%b, required 0", cfg_err);
    end
    cfg_lock = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_single_busy();
    test_back_to_back();
    run_bulk(3'd3, -1, 0, -1, 10, 1'b0);
    run_bulk(3'd5, 20, 10, -1, -1, 1'b0);
    run_bulk(3'd1, -1, 0, -1, -1, 1'b1);
    run_bulk(3'd7, -1, 0, 30, -1, 1'b0);
    test_single();
`ifdef SBOX_CFG_LOCK_EN
    test_lock();
`endif
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending edits, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
